// File: rtl/jtag_vdr_pkg.sv
`default_nettype none
// ============================================================================
// Module  : jtag_vdr_pkg
// Purpose : Selection-code map and decode helpers for the multi-channel
//           virtual-JTAG data register.
//           Fixed codes: 0 IDENT, 1 FLAGS, 2 UART, 3 BYPASS.
//           Channel c occupies codes SEL_CH_BASE+4c .. SEL_CH_BASE+4c+3
//           in the order RADDR, WADDR, RDATA, WDATA.
// Revision: 1.0 - initial release
// ============================================================================
package jtag_vdr_pkg;

    localparam int unsigned SEL_IDENT   = 0;
    localparam int unsigned SEL_FLAGS   = 1;
    localparam int unsigned SEL_UART    = 2;
    localparam int unsigned SEL_BYPASS  = 3;
    localparam int unsigned SEL_CH_BASE = SEL_BYPASS + 1;
    localparam int unsigned SEL_CH_SPAN = 4;

    // Enum values double as the per-channel code offsets.
    typedef enum logic [1:0] {
        KIND_RADDR = 2'd0,
        KIND_WADDR = 2'd1,
        KIND_RDATA = 2'd2,
        KIND_WDATA = 2'd3
    } sel_kind_e;

    // Channel index of a channel code; meaningless for fixed codes.
    function automatic logic [31:0] sel_ch(input logic [31:0] code);
        return (code - SEL_CH_BASE) / SEL_CH_SPAN;
    endfunction

    // Register kind of a channel code; meaningless for fixed codes.
    function automatic sel_kind_e sel_kind(input logic [31:0] code);
        return sel_kind_e'(2'(code - SEL_CH_BASE));
    endfunction

endpackage
`default_nettype wire

// File: rtl/jtag_vdr_chan.sv
`default_nettype none
// ============================================================================
// Module  : jtag_vdr_chan
// Purpose : One RAM channel: read/write address pointers, their delayed
//           auto-increment pipelines and the one-tck write strobe.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           i_vdr               - DR contents, source for pointer loads
//           i_raddr_load/i_waddr_load - pointer load (Update-DR)
//           i_rinc_sched        - schedule a read-pointer increment
//           i_word_done         - a full write word has been shifted in
//           o_raddr/o_waddr     - pointers
//           o_wram_enable       - write strobe
//           o_word_done         - registered word-done (latches wdata)
// Revision: 1.0 - initial release
// ============================================================================
module jtag_vdr_chan
    import jtag_vdr_pkg::*;
#(
    parameter int unsigned DR_LENGTH = 32,
    parameter int unsigned STRIDE    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DR_LENGTH-1:0] i_vdr,
    input  logic                 i_raddr_load,
    input  logic                 i_waddr_load,
    input  logic                 i_rinc_sched,
    input  logic                 i_word_done,
    output logic [DR_LENGTH-1:0] o_raddr,
    output logic [DR_LENGTH-1:0] o_waddr,
    output logic                 o_wram_enable,
    output logic                 o_word_done
);

    localparam logic [DR_LENGTH-1:0] STEP = DR_LENGTH'(STRIDE);

    logic [DR_LENGTH-1:0] raddr_q, raddr_d;
    logic [DR_LENGTH-1:0] waddr_q, waddr_d;
    logic                 rinc_q, rinc_d;
    logic                 word_done_q, word_done_d;
    logic                 strobe_q, strobe_d;
    logic                 winc_q, winc_d;

    always_comb begin
        // A pointer load in the scheduling cycle cancels the increment;
        // a load in the apply cycle simply takes priority below.
        rinc_d      = i_rinc_sched & ~i_raddr_load;
        word_done_d = i_word_done;
        strobe_d    = word_done_q;
        winc_d      = word_done_q & ~i_waddr_load;

        raddr_d = raddr_q;
        if (i_raddr_load) begin
            raddr_d = i_vdr;
        end else if (rinc_q) begin
            raddr_d = raddr_q + STEP;
        end

        // winc_q is coincident with the strobe, so the write uses the old
        // address and the pointer advances at the end of that cycle.
        waddr_d = waddr_q;
        if (i_waddr_load) begin
            waddr_d = i_vdr;
        end else if (winc_q) begin
            waddr_d = waddr_q + STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            raddr_q     <= '0;
            waddr_q     <= '0;
            rinc_q      <= 1'b0;
            word_done_q <= 1'b0;
            strobe_q    <= 1'b0;
            winc_q      <= 1'b0;
        end else begin
            raddr_q     <= raddr_d;
            waddr_q     <= waddr_d;
            rinc_q      <= rinc_d;
            word_done_q <= word_done_d;
            strobe_q    <= strobe_d;
            winc_q      <= winc_d;
        end
    end

    assign o_raddr       = raddr_q;
    assign o_waddr       = waddr_q;
    assign o_wram_enable = strobe_q;
    assign o_word_done   = word_done_q;

endmodule
`default_nettype wire

// File: rtl/jtag_vdr_mc.sv
`default_nettype none
// ============================================================================
// Module  : jtag_vdr_mc
// Purpose : Multi-channel virtual-JTAG data register with streaming RAM
//           reads and writes, IDENT/FLAGS/UART registers and BYPASS.
// Ports   : tck, reset (sync, active high); tdi/vdr_tdo serial path;
//           capture_dr/shift_dr/update_dr TAP strobes; ir_sel decoded IR;
//           rdata_in/raddr_out/waddr_out/wram_enable per-channel RAM side;
//           wdata_out shared write data; flags_out; uart_state, jtag_tx_out,
//           jtag_tx_valid UART side.
// Revision: 1.0 - initial release
// ============================================================================
module jtag_vdr_mc
    import jtag_vdr_pkg::*;
#(
    parameter int unsigned DR_LENGTH  = 32,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned STRIDE     = 1,
    parameter logic [31:0] IDENT      = 32'h97d2f9d1,
    parameter logic [31:0] FLAGS_INIT = 32'h99,
    parameter int unsigned SEL_W      = 6
) (
    input  logic                        tck,
    input  logic                        reset,
    input  logic                        tdi,
    output logic                        vdr_tdo,
    input  logic                        capture_dr,
    input  logic                        shift_dr,
    input  logic                        update_dr,
    input  logic [SEL_W-1:0]            ir_sel,
    input  logic [NUM_CH*DR_LENGTH-1:0] rdata_in,
    input  logic [DR_LENGTH-1:0]        uart_state,
    output logic [NUM_CH*DR_LENGTH-1:0] raddr_out,
    output logic [NUM_CH*DR_LENGTH-1:0] waddr_out,
    output logic [DR_LENGTH-1:0]        wdata_out,
    output logic [NUM_CH-1:0]           wram_enable,
    output logic [DR_LENGTH-1:0]        flags_out,
    output logic [DR_LENGTH-1:0]        jtag_tx_out,
    output logic                        jtag_tx_valid
);

    localparam int unsigned          CNT_W     = $clog2(DR_LENGTH);
    localparam logic [CNT_W-1:0]     CNT_LAST  = CNT_W'(DR_LENGTH - 1);
    localparam logic [DR_LENGTH-1:0] IDENT_EXT = DR_LENGTH'(IDENT);
    localparam logic [DR_LENGTH-1:0] FLAGS_RST = DR_LENGTH'(FLAGS_INIT);

    logic [31:0]          sel_code;
    logic [31:0]          ch_idx;
    sel_kind_e            kind;
    logic                 in_ch;
    logic                 is_ident, is_flags, is_uart;
    logic [NUM_CH-1:0]    sel_raddr, sel_waddr, sel_rdata, sel_wdata;
    logic [NUM_CH-1:0]    word_done;
    logic                 any_rdata, any_stream, cnt_last;
    logic [DR_LENGTH-1:0] rdata_sel;

    logic [DR_LENGTH-1:0] vdr_q, vdr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [DR_LENGTH-1:0] flags_q, flags_d;
    logic [DR_LENGTH-1:0] wdata_q, wdata_d;
    logic [DR_LENGTH-1:0] tx_q, tx_d;
    logic                 tx_valid_q, tx_valid_d;

    assign sel_code = 32'(ir_sel);
    assign ch_idx   = sel_ch(sel_code);
    assign kind     = sel_kind(sel_code);
    // Codes past the last channel fall through every decode: BYPASS.
    assign in_ch    = (sel_code >= SEL_CH_BASE) &&
                      (sel_code <  SEL_CH_BASE + SEL_CH_SPAN * NUM_CH);
    assign is_ident = (sel_code == SEL_IDENT);
    assign is_flags = (sel_code == SEL_FLAGS);
    assign is_uart  = (sel_code == SEL_UART);
    assign cnt_last = (cnt_q == CNT_LAST);

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic hit;
        assign hit          = in_ch && (ch_idx == 32'(c));
        assign sel_raddr[c] = hit && (kind == KIND_RADDR);
        assign sel_waddr[c] = hit && (kind == KIND_WADDR);
        assign sel_rdata[c] = hit && (kind == KIND_RDATA);
        assign sel_wdata[c] = hit && (kind == KIND_WDATA);

        jtag_vdr_chan #(
            .DR_LENGTH (DR_LENGTH),
            .STRIDE    (STRIDE)
        ) u_chan (
            .clk           (tck),
            .rst           (reset),
            .i_vdr         (vdr_q),
            .i_raddr_load  (update_dr & sel_raddr[c]),
            .i_waddr_load  (update_dr & sel_waddr[c]),
            .i_rinc_sched  (sel_rdata[c] & (capture_dr | (shift_dr & cnt_last))),
            .i_word_done   (sel_wdata[c] & shift_dr & cnt_last),
            .o_raddr       (raddr_out[c*DR_LENGTH +: DR_LENGTH]),
            .o_waddr       (waddr_out[c*DR_LENGTH +: DR_LENGTH]),
            .o_wram_enable (wram_enable[c]),
            .o_word_done   (word_done[c])
        );
    end

    assign any_rdata  = |sel_rdata;
    assign any_stream = |(sel_rdata | sel_wdata);

    always_comb begin
        rdata_sel = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel_rdata[i]) begin
                rdata_sel = rdata_in[i*DR_LENGTH +: DR_LENGTH];
            end
        end
    end

    always_comb begin
        vdr_d = vdr_q;
        if (capture_dr) begin
            if (is_ident) begin
                vdr_d = IDENT_EXT;
            end else if (is_uart) begin
                vdr_d = uart_state;
            end else if (any_rdata) begin
                vdr_d = rdata_sel;
            end
        end else if (shift_dr) begin
            // Last bit of a streaming read word reloads the next word;
            // the tdi bit of that shift is dropped.
            if (any_rdata && cnt_last) begin
                vdr_d = rdata_sel;
            end else begin
                vdr_d = {tdi, vdr_q[DR_LENGTH-1:1]};
            end
        end

        cnt_d = cnt_q;
        if (capture_dr || !any_stream) begin
            cnt_d = '0;
        end else if (shift_dr) begin
            cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
        end

        // Only one channel can be in WDATA at a time, but a word_done from
        // a previous selection still latches the data it was shifted with.
        wdata_d    = (|word_done) ? vdr_q : wdata_q;
        flags_d    = (update_dr && is_flags) ? vdr_q : flags_q;
        tx_d       = (update_dr && is_uart)  ? vdr_q : tx_q;
        tx_valid_d = update_dr && is_uart;
    end

    always_ff @(posedge tck) begin
        if (reset) begin
            vdr_q      <= '0;
            cnt_q      <= '0;
            flags_q    <= FLAGS_RST;
            wdata_q    <= '0;
            tx_q       <= '0;
            tx_valid_q <= 1'b0;
        end else begin
            vdr_q      <= vdr_d;
            cnt_q      <= cnt_d;
            flags_q    <= flags_d;
            wdata_q    <= wdata_d;
            tx_q       <= tx_d;
            tx_valid_q <= tx_valid_d;
        end
    end

    assign vdr_tdo       = vdr_q[0];
    assign wdata_out     = wdata_q;
    assign flags_out     = flags_q;
    assign jtag_tx_out   = tx_q;
    assign jtag_tx_valid = tx_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_jtag_vdr_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_jtag_vdr_mc
// Purpose : Directed self-checking bench for jtag_vdr_mc (DR_LENGTH=32,
//           NUM_CH=2) with a 2-tck-latency RAM model on channel 0.
// Revision: 1.0 - initial release
// ============================================================================
module tb_jtag_vdr_mc;

    localparam int DR  = 32;
    localparam int NCH = 2;

    logic              tck = 1'b0;
    logic              reset = 1'b1;
    logic              tdi = 1'b0;
    logic              capture_dr = 1'b0;
    logic              shift_dr = 1'b0;
    logic              update_dr = 1'b0;
    logic [5:0]        ir_sel = 6'd3;
    logic [NCH*DR-1:0] rdata_in;
    logic [DR-1:0]     uart_state = '0;
    logic              vdr_tdo;
    logic [NCH*DR-1:0] raddr_out, waddr_out;
    logic [DR-1:0]     wdata_out, flags_out, jtag_tx_out;
    logic [NCH-1:0]    wram_enable;
    logic              jtag_tx_valid;

    jtag_vdr_mc #(
        .DR_LENGTH (DR),
        .NUM_CH    (NCH),
        .STRIDE    (1),
        .IDENT     (32'h97d2f9d1),
        .FLAGS_INIT(32'h99),
        .SEL_W     (6)
    ) dut (
        .tck          (tck),
        .reset        (reset),
        .tdi          (tdi),
        .vdr_tdo      (vdr_tdo),
        .capture_dr   (capture_dr),
        .shift_dr     (shift_dr),
        .update_dr    (update_dr),
        .ir_sel       (ir_sel),
        .rdata_in     (rdata_in),
        .uart_state   (uart_state),
        .raddr_out    (raddr_out),
        .waddr_out    (waddr_out),
        .wdata_out    (wdata_out),
        .wram_enable  (wram_enable),
        .flags_out    (flags_out),
        .jtag_tx_out  (jtag_tx_out),
        .jtag_tx_valid(jtag_tx_valid)
    );

    always #5 tck = ~tck;

    // RAM model for channel 0: two registered stages after raddr.
    logic [31:0] mem [0:255];
    logic [31:0] rd_p1, rd_p2;
    always @(posedge tck) begin
        rd_p1 <= mem[raddr_out[7:0]];
        rd_p2 <= rd_p1;
    end
    assign rdata_in = {32'hDEAD_BEEF, rd_p2};

    // Write-strobe recorder, sampled on the falling edge.
    int          wr0_cnt = 0;
    int          wr1_cnt = 0;
    logic [31:0] wr0_addr [0:63];
    logic [31:0] wr0_data [0:63];
    logic [31:0] wr1_addr [0:63];
    logic [31:0] wr1_data [0:63];
    always @(negedge tck) begin
        if (wram_enable[0]) begin
            wr0_addr[wr0_cnt % 64] <= waddr_out[31:0];
            wr0_data[wr0_cnt % 64] <= wdata_out;
            wr0_cnt                <= wr0_cnt + 1;
        end
        if (wram_enable[1]) begin
            wr1_addr[wr1_cnt % 64] <= waddr_out[63:32];
            wr1_data[wr1_cnt % 64] <= wdata_out;
            wr1_cnt                <= wr1_cnt + 1;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge tck);
            #1;
        end
    endtask

    // Shifts one 32-bit word LSB first, collecting TDO before each edge.
    // Leaves shift_dr high so consecutive calls stream without a gap.
    task automatic shift_word(input logic [31:0] din, output logic [31:0] dout);
        for (int i = 0; i < 32; i++) begin
            dout[i]  = vdr_tdo;
            tdi      = din[i];
            shift_dr = 1'b1;
            cyc(1);
        end
    endtask

    task automatic capture(input logic [5:0] sel);
        ir_sel     = sel;
        capture_dr = 1'b1;
        cyc(1);
        capture_dr = 1'b0;
    endtask

    task automatic load_reg(input logic [5:0] sel, input logic [31:0] val);
        logic [31:0] dummy;
        ir_sel = sel;
        shift_word(val, dummy);
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        cyc(1);
        update_dr = 1'b0;
    endtask

    logic [31:0] rx, rx1;
    logic [31:0] wpat [0:2];
    int          b0, b1;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE_0000 | 32'(i);
        mem[8'h20] = 32'h1234_5678;
        mem[8'h21] = 32'hCAFE_F00D;
        wpat[0] = 32'h0000_000A;
        wpat[1] = 32'h0000_000B;
        wpat[2] = 32'h0000_000C;

        cyc(3);
        reset = 1'b0;
        cyc(1);
        check("rst_flags", flags_out, 32'h99);
        check("rst_wdata", wdata_out, 32'h0);
        check("rst_wram", 32'(wram_enable), 32'h0);
        check("rst_waddr1", waddr_out[63:32], 32'h0);
        check("rst_raddr0", raddr_out[31:0], 32'h0);
        check("rst_txvalid", 32'(jtag_tx_valid), 32'h0);
        check("rst_tdo", 32'(vdr_tdo), 32'h0);

        // IDENT read-out
        capture(6'd0);
        shift_word(32'h0, rx);
        shift_dr = 1'b0;
        check("ident", rx, 32'h97d2f9d1);
        check("flags_after_ident", flags_out, 32'h99);

        // Streaming write of three words on channel 1
        load_reg(6'd9, 32'h10);
        check("waddr1_load", waddr_out[63:32], 32'h10);
        b0 = wr0_cnt;
        b1 = wr1_cnt;
        capture(6'd11);
        for (int k = 0; k < 3; k++) shift_word(wpat[k], rx);
        shift_dr = 1'b0;
        cyc(4);
        check("wr1_count", 32'(wr1_cnt - b1), 32'd3);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("wr1_addr%0d", k), wr1_addr[(b1 + k) % 64], 32'h10 + 32'(k));
            check($sformatf("wr1_data%0d", k), wr1_data[(b1 + k) % 64], wpat[k]);
        end
        check("wr0_silent", 32'(wr0_cnt - b0), 32'd0);
        check("waddr1_end", waddr_out[63:32], 32'h13);

        // Streaming read of two words on channel 0
        load_reg(6'd4, 32'h20);
        cyc(3);
        check("raddr0_load", raddr_out[31:0], 32'h20);
        capture(6'd6);
        shift_word(32'h0, rx);
        shift_word(32'h0, rx1);
        shift_dr = 1'b0;
        cyc(2);
        check("rd_word0", rx, 32'h1234_5678);
        check("rd_word1", rx1, 32'hCAFE_F00D);
        // capture plus the reloads at shifts 32 and 64 each advance once
        check("raddr0_end", raddr_out[31:0], 32'h23);

        // Partial word then capture: counter must restart
        load_reg(6'd9, 32'h40);
        b1 = wr1_cnt;
        capture(6'd11);
        shift_word(32'h1111_2222, rx);
        for (int i = 0; i < 8; i++) begin
            tdi = 1'b1;
            shift_dr = 1'b1;
            cyc(1);
        end
        shift_dr = 1'b0;
        cyc(4);
        check("partial_count", 32'(wr1_cnt - b1), 32'd1);
        check("partial_addr", wr1_addr[b1 % 64], 32'h40);
        check("partial_data", wr1_data[b1 % 64], 32'h1111_2222);
        b1 = wr1_cnt;
        capture(6'd11);
        shift_word(32'h3333_4444, rx);
        shift_dr = 1'b0;
        cyc(4);
        check("recap_count", 32'(wr1_cnt - b1), 32'd1);
        check("recap_addr", wr1_addr[b1 % 64], 32'h41);
        check("recap_data", wr1_data[b1 % 64], 32'h3333_4444);

        // Address wrap on channel 0
        load_reg(6'd5, 32'hFFFF_FFFF);
        check("waddr0_max", waddr_out[31:0], 32'hFFFF_FFFF);
        b0 = wr0_cnt;
        capture(6'd7);
        shift_word(32'h0BAD_0001, rx);
        shift_dr = 1'b0;
        cyc(4);
        check("wrap_count", 32'(wr0_cnt - b0), 32'd1);
        check("wrap_wr_addr", wr0_addr[b0 % 64], 32'hFFFF_FFFF);
        check("wrap_waddr0", waddr_out[31:0], 32'h0);

        // WADDR load in the same cycle the increment would apply
        b0 = wr0_cnt;
        capture(6'd7);
        shift_word(32'h0000_0077, rx);
        shift_dr = 1'b0;
        cyc(1);
        ir_sel    = 6'd5;
        update_dr = 1'b1;
        cyc(1);
        update_dr = 1'b0;
        cyc(2);
        check("coll_count", 32'(wr0_cnt - b0), 32'd1);
        check("coll_wr_addr", wr0_addr[b0 % 64], 32'h0);
        check("coll_wr_data", wr0_data[b0 % 64], 32'h77);
        check("coll_waddr0", waddr_out[31:0], 32'h77);

        // FLAGS and UART
        load_reg(6'd1, 32'h5A);
        check("flags_load", flags_out, 32'h5A);
        uart_state = 32'h1357_9BDF;
        capture(6'd2);
        shift_word(32'h0000_00C3, rx);
        shift_dr  = 1'b0;
        update_dr = 1'b1;
        cyc(1);
        update_dr = 1'b0;
        check("uart_capture", rx, 32'h1357_9BDF);
        check("tx_out", jtag_tx_out, 32'hC3);
        check("tx_valid_hi", 32'(jtag_tx_valid), 32'h1);
        cyc(1);
        check("tx_valid_lo", 32'(jtag_tx_valid), 32'h0);

        // Out-of-range code behaves as BYPASS
        b0 = wr0_cnt;
        b1 = wr1_cnt;
        load_reg(6'd12, 32'hFFFF_0000);
        cyc(3);
        check("byp_flags", flags_out, 32'h5A);
        check("byp_waddr1", waddr_out[63:32], 32'h42);
        check("byp_raddr1", raddr_out[63:32], 32'h0);
        check("byp_writes", 32'((wr0_cnt - b0) + (wr1_cnt - b1)), 32'd0);

        // Reset on the word_done cycle
        b1 = wr1_cnt;
        capture(6'd11);
        shift_word(32'hDEAD_0001, rx);
        shift_dr = 1'b0;
        reset    = 1'b1;
        cyc(1);
        reset    = 1'b0;
        check("mrst_wram", 32'(wram_enable), 32'h0);
        check("mrst_wdata", wdata_out, 32'h0);
        check("mrst_flags", flags_out, 32'h99);
        check("mrst_waddr1", waddr_out[63:32], 32'h0);
        check("mrst_raddr0", raddr_out[31:0], 32'h0);
        check("mrst_txout", jtag_tx_out, 32'h0);
        check("mrst_tdo", 32'(vdr_tdo), 32'h0);
        cyc(3);
        check("mrst_no_write", 32'(wr1_cnt - b1), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
